// File: rtl/data_mem_responder_pkg.sv
// ============================================================
// data_mem_responder_pkg : shared sizes, FSM states, err bits
// Revision : 1.0
// ============================================================
`default_nettype none

package data_mem_responder_pkg;

    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;

    localparam int ERR_CONFLICT = 0;
    localparam int ERR_EARLY    = 1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_dmem_array.sv
// ============================================================
// dmem_array : storage array, one write port, async read port
// Revision : 1.0
// ============================================================
`default_nettype none

module dmem_array
    import data_mem_responder_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array itself: contents survive reset unless the FSM clears them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================
// data_mem_responder : 128x32 zero-latency data memory with
//                      clear FSM, sticky errors, access counters
// Revision : 1.0
// ============================================================
`default_nettype none

module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int CLEAR_ON_RESET = 1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CEN,
    input  logic              WEN,
    input  logic              OEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] Data2Mem,
    output logic [DATA_W-1:0] ReadDataMem,
    output logic              init_done,
    output logic [1:0]        err,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam bit DO_CLEAR = (CLEAR_ON_RESET != 0);

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;

    logic              ready;
    logic              access_en;
    logic              wr_acc;
    logic              rd_acc;
    logic              early_acc;
    logic              conflict;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    assign ready     = (state == ST_READY);
    assign access_en = !rst && !CEN;
    assign wr_acc    = access_en && ready && !WEN;
    assign rd_acc    = access_en && ready && WEN && !OEN;
    assign early_acc = access_en && !ready && (!WEN || !OEN);
    assign conflict  = wr_acc && !OEN;

    // The clear sequence owns the write port until READY; user writes only afterwards.
    assign mem_we    = wr_acc || (!rst && !ready);
    assign mem_waddr = ready ? A : clr_ptr;
    assign mem_wdata = ready ? Data2Mem : '0;

    assign ReadDataMem = rd_acc ? mem_rdata : '0;
    assign init_done   = ready && !(DO_CLEAR && rst);

    dmem_array u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (A),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DO_CLEAR ? ST_CLEAR : ST_READY;
            clr_ptr  <= '0;
            err      <= '0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_ptr <= clr_ptr + ADDR_W'(1);
                    if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                        state <= ST_READY;
                    end
                end
                default: state <= ST_READY;
            endcase

            if (conflict) begin
                err[ERR_CONFLICT] <= 1'b1;
            end
            if (early_acc) begin
                err[ERR_EARLY] <= 1'b1;
            end

            if (wr_acc && (wr_count != '1)) begin
                wr_count <= wr_count + CNT_W'(1);
            end
            if (rd_acc && (rd_count != '1)) begin
                rd_count <= rd_count + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter CLEAR_ON_RESET, default 1, meaning 1 = zero all 128 words after reset, 0 = skip clearing.
REQ-002 Parameter CNT_W, default 16, meaning width of the access counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 CEN  input  1  chip enable, active low.
REQ-006 WEN  input  1  write enable, active low.
REQ-007 OEN  input  1  output (read) enable, active low.
REQ-008 A  input  7  word address, 0..127.
REQ-009 Data2Mem  input  32  write data.
REQ-010 ReadDataMem  output  32  read data.
REQ-011 init_done  output  1  high when the array is accepting accesses.
REQ-012 err  output  2  sticky protocol errors: bit0 = WEN/OEN conflict; bit1 = access before init_done.
REQ-013 rd_count  output  CNT_W  accepted reads, saturating.
REQ-014 wr_count  output  CNT_W  accepted writes, saturating.

Function
REQ-015 Storage SHALL be 128 x 32-bit words, indexed directly by A; no wrap or out-of-range case exists.
REQ-016 The FSM SHALL have two states, CLEAR and READY; init_done = (state == READY).
REQ-017 In CLEAR, one word SHALL be written with zero per cycle at clr_ptr, starting at 0; after the write at clr_ptr = 127 the FSM SHALL enter READY, with init_done high 128 cycles after rst deasserts.
REQ-018 With CLEAR_ON_RESET = 0, reset SHALL enter READY directly, init_done SHALL be high the first cycle after reset, and array contents SHALL be left unchanged.
REQ-019 A write SHALL be accepted when READY, CEN = 0 and WEN = 0; mem[A] takes Data2Mem at that rising edge.
REQ-020 A read SHALL be accepted when READY, CEN = 0, OEN = 0 and WEN = 1; ReadDataMem = mem[A] combinationally in the same cycle (zero-latency, single-cycle-core compatible).
REQ-021 ReadDataMem SHALL be 32'h0 whenever no read is accepted.
REQ-022 CEN = 0 with WEN = 0 and OEN = 0 SHALL perform the write only, drive ReadDataMem = 0, and set err[0].
REQ-023 Read and write to the same address in consecutive cycles: the read SHALL return the value written in the prior cycle (no stale data).
REQ-024 Any access with CEN = 0 and WEN = 0 or OEN = 0 while in CLEAR SHALL be ignored (no write, ReadDataMem = 0, no count) and SHALL set err[1].
REQ-025 CEN = 1 SHALL be idle regardless of WEN/OEN: no access, no error.
REQ-026 rd_count/wr_count SHALL increment by 1 per accepted read/write and hold at all-ones.
REQ-027 err bits SHALL stay set until reset.

Reset
REQ-028 On rst = 1 at a rising edge: state = CLEAR (or READY if CLEAR_ON_RESET = 0), clr_ptr = 0, err = 0, rd_count = 0, wr_count = 0.
REQ-029 Reset asserted mid-CLEAR SHALL restart clearing from word 0; reset asserted in READY SHALL re-clear the array when CLEAR_ON_RESET = 1.
REQ-030 During rst = 1, no write SHALL be accepted, ReadDataMem SHALL be 0, and init_done SHALL be 0 when CLEAR_ON_RESET = 1.

Structure
REQ-031 The shared package SHALL hold the memory depth (128), the address width (7), the data width (32), the FSM state enum, and the err bit index constants.
REQ-032 The storage array SHALL be one sub-module, dmem_array (one write port, one asynchronous read port); the FSM, error flags and counters SHALL live in the top module.

Verification
REQ-033 Reset, then 130 idle cycles -> init_done rises exactly at cycle 128; reads of A = 0, 64 and 127 return 0.
REQ-034 Write 32'hDEADBEEF to A = 5, then read A = 5 next cycle -> ReadDataMem = 32'hDEADBEEF, wr_count = 1, rd_count = 1.
REQ-035 CEN = 0, WEN = 0, OEN = 0, A = 9, Data2Mem = 32'h12345678 -> ReadDataMem = 0, err = 2'b01, and a later read of A = 9 returns 32'h12345678.
REQ-036 Write to A = 3 issued at cycle 10 after reset (in CLEAR) -> err = 2'b10, wr_count = 0, and A = 3 reads 0 after init_done.
REQ-037 Assert rst for 1 cycle at clr_ptr = 60 -> init_done rises 128 cycles after rst deasserts; err and counters are 0.
REQ-038 With CNT_W = 4, issue 20 reads -> rd_count saturates at 4'hF.
